game_pixel_gen: RTL and testbench
=================================

# game_pixel_gen

Parametrised, self-contained pixel generator for the VGA paddle-and-ball game. It owns paddle and ball motion, a game-state machine with lives and score, and colour selection. It sits between the VGA sync counter (pixel_x/pixel_y/video_on/p_tick) and the DAC pins. The RGB output is registered, which is new relative to the earlier combinational colour mux.

## Interface
- H_ACTIVE, 640: visible width, pixels
- V_ACTIVE, 480: visible height, lines
- PAD_W, 64 / PAD_H, 8: paddle size
- PAD_Y, 450: paddle top row, fixed
- PAD_STEP, 4: paddle pixels per frame
- BALL_SIZE, 8: ball square side
- BALL_STEP, 2: ball pixels per frame, per axis
- LIVES, 3: lives per game (1..15)
- BG_RGB 12'h000, BALL_RGB 12'hFFF, PAD_RGB 12'h0F0, OVER_RGB 12'hF00: colours

Ports:
- clk  in  1  system clock
- rstn  in  1  reset, asynchronous, active-low
- video_on  in  1  visible region
- p_tick  in  1  pixel-rate enable
- right_k, left_k, start_k  in  1  keys, level, already synchronised
- pixel_x, pixel_y  in  10  current pixel
- r, g, b  out  4  colour, registered
- lives  out  4  remaining lives
- score  out  8  paddle hits this game, saturating
- game_over  out  1  high in OVER

## Operation
- **Frame tick:** refr_tick = p_tick & (pixel_y == V_ACTIVE+1) & (pixel_x == 0). It is exactly one clk per frame. All motion, key sampling and FSM moves except MISS happen only on refr_tick.
- **FSM states:** IDLE (reset), PLAY, MISS, OVER.
  - IDLE→PLAY: start_k=1 at refr_tick.
  - PLAY→MISS: at refr_tick when ball_y ≥ V_ACTIVE−BALL_SIZE after the update.
  - MISS is one clk: lives decrements. Next clk goes to OVER if the new lives=0, else IDLE.
  - OVER→IDLE: start_k=1 at refr_tick. On this transition lives reloads to LIVES and score clears.
- **Paddle:** paddle_x is the left edge; reset value is (H_ACTIVE−PAD_W)/2. Updates at refr_tick in IDLE and PLAY.
  - right_k only: +PAD_STEP, clamped to H_ACTIVE−PAD_W.
  - left_k only: −PAD_STEP, clamped to 0. No unsigned underflow.
  - Both keys or neither: hold.
  - Frozen in MISS and OVER.
- **Ball in IDLE:** parked on the paddle. ball_x = paddle_x+(PAD_W−BALL_SIZE)/2, ball_y = PAD_Y−BALL_SIZE, dx=+1, dy=−1 (up). These are updated every clk, so the ball tracks the paddle.
- **Ball in PLAY:** at refr_tick, moves ±BALL_STEP per axis.
  - Left wall: dx=−1 and ball_x < BALL_STEP → ball_x=0, dx=+1.
  - Right wall: same rule at H_ACTIVE−BALL_SIZE.
  - Top wall: same rule at 0.
  - Paddle hit requires all of: dy=+1, the next bottom edge in [PAD_Y, PAD_Y+PAD_H], ball_x+BALL_SIZE > paddle_x, ball_x < paddle_x+PAD_W. Result: ball_y=PAD_Y−BALL_SIZE, dy=−1, score+1 (saturates at 255).
  - Wall and paddle on the same tick: both axes reflect independently.
- **Colour priority:** ~video_on → 0. Else ball pixel → BALL_RGB. Else paddle pixel → PAD_RGB (OVER_RGB in OVER). Else BG_RGB.
  - Ball pixel: pixel_x in [ball_x, ball_x+BALL_SIZE) and pixel_y in [ball_y, ball_y+BALL_SIZE).
  - Paddle pixel: same test using paddle_x/PAD_W/PAD_Y/PAD_H.
- **Arithmetic:** 11-bit intermediates for all edge sums; compares are unsigned.

## Timing
- Reset values: r/g/b=0, lives=LIVES, score=0, game_over=0, state=IDLE, paddle centred, ball parked.
- Reset is asynchronous. Asserting it mid-PLAY returns every register to reset values immediately.
- RGB latency: r,g,b reflect pixel_x/pixel_y/video_on of the previous clk, so the latency is exactly 1 clk. RGB is registered every clk, not only on p_tick.
- Positions change only on the clk after refr_tick. One frame is drawn with one consistent position set.
- lives, score and game_over are registered. game_over rises the clk after MISS.
- start_k held across many frames triggers one transition per refr_tick. OVER→IDLE→PLAY therefore takes two frames.

## Test plan
- **Reset:** reset then release, pixel (316..323, 442..449) visible → next clk RGB=12'hFFF (parked ball, paddle_x=288). Pixel (300,452) → 12'h0F0. lives=3, score=0.
- **Paddle clamp:** hold left_k 80 frames → paddle_x=0, no wrap. Hold right_k 200 frames → paddle_x=576. Both keys → unchanged.
- **Walls:** serve, let the ball reach ball_x=0 → dx flips, ball_x never underflows. Top wall: ball_y=0 → dy=+1.
- **Paddle hit:** align the paddle under the descending ball → ball_y=442, dy=−1, score increments by 1.
- **Miss and game over:** never intercept → lives 3→2→1→0 over three misses. game_over=1, paddle drawn 12'hF00. start_k → lives=3, score=0, IDLE.
- **Blanking and async reset:** video_on=0 at a ball pixel → RGB=0. Pulse rstn low mid-PLAY between clk edges → outputs at reset values immediately.

Source files
------------

// File: rtl/game_pixel_gen.sv
// game_pixel_gen: pixel generator for the VGA paddle-and-ball game.
// Owns paddle/ball motion, the IDLE/PLAY/MISS/OVER game FSM with lives
// and score, and a registered colour output (1 clk after pixel_x/pixel_y).
//
// Ports:
//   clk                    system clock
//   rstn                   asynchronous active-low reset
//   video_on               visible region flag from the sync counter
//   p_tick                 pixel-rate enable
//   right_k/left_k/start_k level keys, already synchronised
//   pixel_x/pixel_y        current pixel coordinate
//   r/g/b                  registered 4-bit colour channels
//   lives                  remaining lives
//   score                  paddle hits this game, saturating at 255
//   game_over              high while in OVER
module game_pixel_gen #(
  parameter int          H_ACTIVE  = 640,
  parameter int          V_ACTIVE  = 480,
  parameter int          PAD_W     = 64,
  parameter int          PAD_H     = 8,
  parameter int          PAD_Y     = 450,
  parameter int          PAD_STEP  = 4,
  parameter int          BALL_SIZE = 8,
  parameter int          BALL_STEP = 2,
  parameter int          LIVES     = 3,
  parameter logic [11:0] BG_RGB    = 12'h000,
  parameter logic [11:0] BALL_RGB  = 12'hFFF,
  parameter logic [11:0] PAD_RGB   = 12'h0F0,
  parameter logic [11:0] OVER_RGB  = 12'hF00
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       video_on,
  input  logic       p_tick,
  input  logic       right_k,
  input  logic       left_k,
  input  logic       start_k,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  output logic [3:0] r,
  output logic [3:0] g,
  output logic [3:0] b,
  output logic [3:0] lives,
  output logic [7:0] score,
  output logic       game_over
);

  typedef enum logic [1:0] {IDLE, PLAY, MISS, OVER} state_t;

  localparam logic [10:0] STEP_P     = 11'(PAD_STEP);
  localparam logic [10:0] STEP_B     = 11'(BALL_STEP);
  localparam logic [10:0] SIZE_B     = 11'(BALL_SIZE);
  localparam logic [10:0] PAD_X_MAX  = 11'(H_ACTIVE - PAD_W);
  localparam logic [10:0] BALL_X_MAX = 11'(H_ACTIVE - BALL_SIZE);
  localparam logic [10:0] MISS_Y     = 11'(V_ACTIVE - BALL_SIZE);
  localparam logic [10:0] PAD_TOP    = 11'(PAD_Y);
  localparam logic [10:0] PAD_BOT    = 11'(PAD_Y + PAD_H);
  localparam logic [10:0] PAD_WID    = 11'(PAD_W);
  localparam logic [10:0] PAD_HGT    = 11'(PAD_H);
  // No floor: the vertical axis never clamps when moving down.
  localparam logic [10:0] Y_OPEN     = 11'h7FF;
  localparam logic [9:0]  PAD_Y_V    = 10'(PAD_Y);
  localparam logic [9:0]  PARK_OFS   = 10'((PAD_W - BALL_SIZE) / 2);
  localparam logic [9:0]  PARK_Y     = 10'(PAD_Y - BALL_SIZE);
  localparam logic [9:0]  PAD_X_RST  = 10'((H_ACTIVE - PAD_W) / 2);
  localparam logic [9:0]  REFR_Y     = 10'(V_ACTIVE + 1);
  localparam logic [3:0]  LIVES_INIT = 4'(LIVES);

  // Paddle step with clamping at both screen edges; both/neither keys hold.
  function automatic logic [9:0] pad_move(input logic [9:0] px, input logic rk, input logic lk);
    logic [10:0] p;
    p = {1'b0, px};
    if (rk && !lk) begin
      if (p + STEP_P > PAD_X_MAX) return 10'(PAD_X_MAX);
      return 10'(p + STEP_P);
    end
    if (lk && !rk) begin
      if (p < STEP_P) return 10'd0;
      return 10'(p - STEP_P);
    end
    return px;
  endfunction

  // One ball axis step with wall reflection; returns {dir_pos, new_pos}.
  function automatic logic [10:0] axis_move(input logic [9:0] pos, input logic dir_pos,
                                            input logic [10:0] lim);
    logic [10:0] p;
    p = {1'b0, pos};
    if (dir_pos) begin
      if (p + STEP_B > lim) return {1'b0, 10'(lim)};
      return {1'b1, 10'(p + STEP_B)};
    end
    if (p < STEP_B) return {1'b1, 10'd0};
    return {1'b0, 10'(p - STEP_B)};
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? 8'hFF : v + 8'd1;
  endfunction

  function automatic logic in_box(input logic [9:0] px, input logic [9:0] py,
                                  input logic [9:0] x0, input logic [9:0] y0,
                                  input logic [10:0] w, input logic [10:0] h);
    return ({1'b0, px} >= {1'b0, x0}) && ({1'b0, px} < {1'b0, x0} + w) &&
           ({1'b0, py} >= {1'b0, y0}) && ({1'b0, py} < {1'b0, y0} + h);
  endfunction

  state_t      state_q, state_d;
  logic [9:0]  paddle_x, paddle_d;
  logic [9:0]  ball_x, ball_x_d, ball_y, ball_y_d;
  logic        ball_dx, dx_d, ball_dy, dy_d;
  logic [3:0]  lives_q, lives_d;
  logic [7:0]  score_q, score_d;
  logic        game_over_q;
  logic [10:0] ax, ay;
  logic        hit;
  logic        refr_tick;
  logic [11:0] rgb_p0, rgb_p1;

  assign refr_tick = p_tick && (pixel_y == REFR_Y) && (pixel_x == 10'd0);

  // Stage p0: game state next-values and combinational colour select
  always_comb begin
    state_d  = state_q;
    paddle_d = paddle_x;
    ball_x_d = ball_x;
    ball_y_d = ball_y;
    dx_d     = ball_dx;
    dy_d     = ball_dy;
    lives_d  = lives_q;
    score_d  = score_q;
    ax       = '0;
    ay       = '0;
    hit      = 1'b0;
    case (state_q)
      IDLE: begin
        ball_x_d = paddle_x + PARK_OFS;
        ball_y_d = PARK_Y;
        dx_d     = 1'b1;
        dy_d     = 1'b0;
        if (refr_tick) begin
          paddle_d = pad_move(paddle_x, right_k, left_k);
          if (start_k) state_d = PLAY;
        end
      end
      PLAY: begin
        if (refr_tick) begin
          paddle_d = pad_move(paddle_x, right_k, left_k);
          ax       = axis_move(ball_x, ball_dx, BALL_X_MAX);
          ay       = axis_move(ball_y, ball_dy, Y_OPEN);
          hit      = ball_dy &&
                     ({1'b0, ay[9:0]} + SIZE_B >= PAD_TOP) &&
                     ({1'b0, ay[9:0]} + SIZE_B <= PAD_BOT) &&
                     ({1'b0, ball_x} + SIZE_B > {1'b0, paddle_x}) &&
                     ({1'b0, ball_x} < {1'b0, paddle_x} + PAD_WID);
          ball_x_d = ax[9:0];
          dx_d     = ax[10];
          if (hit) begin
            ball_y_d = PARK_Y;
            dy_d     = 1'b0;
            score_d  = sat_inc(score_q);
          end else begin
            ball_y_d = ay[9:0];
            dy_d     = ay[10];
          end
          if ({1'b0, ball_y_d} >= MISS_Y) state_d = MISS;
        end
      end
      MISS: begin
        lives_d = lives_q - 4'd1;
        state_d = (lives_q <= 4'd1) ? OVER : IDLE;
      end
      OVER: begin
        if (refr_tick && start_k) begin
          state_d = IDLE;
          lives_d = LIVES_INIT;
          score_d = 8'd0;
        end
      end
      default: state_d = IDLE;
    endcase

    rgb_p0 = BG_RGB;
    if (!video_on)
      rgb_p0 = 12'h000;
    else if (in_box(pixel_x, pixel_y, ball_x, ball_y, SIZE_B, SIZE_B))
      rgb_p0 = BALL_RGB;
    else if (in_box(pixel_x, pixel_y, paddle_x, PAD_Y_V, PAD_WID, PAD_HGT))
      rgb_p0 = (state_q == OVER) ? OVER_RGB : PAD_RGB;
  end

  // Stage p1: registered state and colour
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      paddle_x    <= PAD_X_RST;
      ball_x      <= PAD_X_RST + PARK_OFS;
      ball_y      <= PARK_Y;
      ball_dx     <= 1'b1;
      ball_dy     <= 1'b0;
      lives_q     <= LIVES_INIT;
      score_q     <= 8'd0;
      game_over_q <= 1'b0;
      rgb_p1      <= 12'h000;
    end else begin
      paddle_x    <= paddle_d;
      ball_x      <= ball_x_d;
      ball_y      <= ball_y_d;
      ball_dx     <= dx_d;
      ball_dy     <= dy_d;
      lives_q     <= lives_d;
      score_q     <= score_d;
      game_over_q <= (state_d == OVER);
      rgb_p1      <= rgb_p0;
    end
  end

  assign r         = rgb_p1[11:8];
  assign g         = rgb_p1[7:4];
  assign b         = rgb_p1[3:0];
  assign lives     = lives_q;
  assign score     = score_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_game_pixel_gen.sv
// Testbench for game_pixel_gen: directed stimulus with hand-computed
// expectations pushed into a scoreboard queue, checked by a monitor.
module tb_game_pixel_gen;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       video_on = 1'b0;
  logic       p_tick = 1'b0;
  logic       right_k = 1'b0;
  logic       left_k = 1'b0;
  logic       start_k = 1'b0;
  logic [9:0] pixel_x = 10'd0;
  logic [9:0] pixel_y = 10'd0;
  logic [3:0] r, g, b, lives;
  logic [7:0] score;
  logic       game_over;

  always #5 clk = ~clk;

  game_pixel_gen dut (
    .clk      (clk),
    .rstn     (rstn),
    .video_on (video_on),
    .p_tick   (p_tick),
    .right_k  (right_k),
    .left_k   (left_k),
    .start_k  (start_k),
    .pixel_x  (pixel_x),
    .pixel_y  (pixel_y),
    .r        (r),
    .g        (g),
    .b        (b),
    .lives    (lives),
    .score    (score),
    .game_over(game_over)
  );

  // kind: 0 = rgb, 1 = lives, 2 = score, 3 = game_over
  typedef struct {
    int          kind;
    logic [11:0] exp;
    string       name;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  logic req = 1'b0;
  logic req_d = 1'b0;
  logic async_chk = 1'b0;

  // Output-valid strobe: registered colour is ready one clk after a request.
  always @(posedge clk) req_d <= req;

  function automatic logic [11:0] actual(input int kind);
    case (kind)
      0:       return {r, g, b};
      1:       return {8'h00, lives};
      2:       return {4'h0, score};
      default: return {11'h000, game_over};
    endcase
  endfunction

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or posedge async_chk);
      if (req_d || async_chk) begin
        while (q.size() > 0) begin
          e = q.pop_front();
          total++;
          if (actual(e.kind) !== e.exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", e.name, actual(e.kind), e.exp);
          end
        end
      end
    end
  end

  task automatic expect_val(input int kind, input logic [11:0] v, input string nm);
    exp_t e;
    e.kind = kind;
    e.exp  = v;
    e.name = nm;
    q.push_back(e);
  endtask

  task automatic fire();
    req = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
  endtask

  task automatic probe(input int x, input int y, input logic von,
                       input logic [11:0] v, input string nm);
    @(negedge clk);
    #1;
    pixel_x  = 10'(x);
    pixel_y  = 10'(y);
    video_on = von;
    p_tick   = 1'b0;
    expect_val(0, v, nm);
    fire();
  endtask

  task automatic ctrs(input int l, input int s, input logic go, input string nm);
    @(negedge clk);
    #1;
    expect_val(1, 12'(l), {nm, "_lives"});
    expect_val(2, 12'(s), {nm, "_score"});
    expect_val(3, {11'h000, go}, {nm, "_over"});
    fire();
  endtask

  // One refr_tick per iteration, keys held at the given levels.
  task automatic frames(input int n, input logic rk, input logic lk, input logic sk);
    repeat (n) begin
      @(negedge clk);
      #1;
      pixel_x = 10'd0;
      pixel_y = 10'd481;
      p_tick  = 1'b1;
      right_k = rk;
      left_k  = lk;
      start_k = sk;
      @(negedge clk);
      #1;
      p_tick  = 1'b0;
      pixel_y = 10'd0;
    end
    right_k = 1'b0;
    left_k  = 1'b0;
    start_k = 1'b0;
  endtask

  // Drop rstn between clock edges and check outputs without waiting for an edge.
  task automatic async_reset_check(input string nm);
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    expect_val(0, 12'h000, {nm, "_rgb"});
    expect_val(1, 12'd3, {nm, "_lives"});
    expect_val(2, 12'd0, {nm, "_score"});
    expect_val(3, 12'd0, {nm, "_over"});
    async_chk = 1'b1;
    #1 async_chk = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    async_reset_check("rst");
    @(negedge clk);
    #1 rstn = 1'b1;

    // Reset picture: paddle at 288, ball parked at (316,442)
    probe(316, 442, 1'b1, 12'hFFF, "park_tl");
    probe(323, 449, 1'b1, 12'hFFF, "park_br");
    probe(324, 449, 1'b1, 12'h000, "park_right");
    probe(300, 452, 1'b1, 12'h0F0, "pad_rst");
    probe(287, 452, 1'b1, 12'h000, "pad_rst_left");

    // Paddle clamps
    frames(80, 1'b0, 1'b1, 1'b0);
    probe(0, 452, 1'b1, 12'h0F0, "pad_min");
    probe(64, 452, 1'b1, 12'h000, "pad_min_end");
    probe(28, 442, 1'b1, 12'hFFF, "park_min");
    frames(200, 1'b1, 1'b0, 1'b0);
    probe(576, 452, 1'b1, 12'h0F0, "pad_max");
    probe(575, 452, 1'b1, 12'h000, "pad_max_left");
    probe(639, 457, 1'b1, 12'h0F0, "pad_max_end");
    probe(604, 442, 1'b1, 12'hFFF, "park_max");
    frames(5, 1'b1, 1'b1, 1'b0);
    probe(576, 452, 1'b1, 12'h0F0, "both_keys");
    probe(575, 452, 1'b1, 12'h000, "both_keys_left");

    // Serve from x=604; tick n: x = 604+2n up to 632, y = 442-2n
    frames(1, 1'b0, 1'b0, 1'b1);
    frames(15, 1'b0, 1'b0, 1'b0);
    probe(632, 412, 1'b1, 12'hFFF, "rwall");
    probe(631, 412, 1'b1, 12'h000, "rwall_left");
    frames(206, 1'b0, 1'b0, 1'b0);
    probe(220, 0, 1'b1, 12'hFFF, "top");
    probe(220, 8, 1'b1, 12'h000, "top_below");
    frames(1, 1'b0, 1'b0, 1'b0);
    probe(218, 0, 1'b1, 12'hFFF, "top_hold");
    frames(1, 1'b0, 1'b0, 1'b0);
    probe(216, 2, 1'b1, 12'hFFF, "top_down");
    probe(216, 1, 1'b1, 12'h000, "top_down_gap");
    frames(108, 1'b0, 1'b0, 1'b0);
    probe(0, 218, 1'b1, 12'hFFF, "lwall");
    frames(1, 1'b0, 1'b0, 1'b0);
    probe(0, 220, 1'b1, 12'hFFF, "lwall_hold");
    probe(0, 219, 1'b1, 12'h000, "lwall_hold_gap");
    frames(1, 1'b0, 1'b0, 1'b0);
    probe(2, 222, 1'b1, 12'hFFF, "lwall_out");
    probe(1, 222, 1'b1, 12'h000, "lwall_out_left");

    // Bring paddle to x=200 under the descending ball
    frames(94, 1'b0, 1'b1, 1'b0);
    frames(15, 1'b0, 1'b0, 1'b0);
    probe(220, 440, 1'b1, 12'hFFF, "pre_hit");
    probe(200, 452, 1'b1, 12'h0F0, "pad_aim");
    probe(199, 452, 1'b1, 12'h000, "pad_aim_left");
    ctrs(3, 0, 1'b0, "pre_hit");
    frames(1, 1'b0, 1'b0, 1'b0);
    probe(222, 442, 1'b1, 12'hFFF, "hit");
    probe(222, 441, 1'b1, 12'h000, "hit_above");
    ctrs(3, 1, 1'b0, "hit");
    frames(1, 1'b0, 1'b0, 1'b0);
    probe(224, 440, 1'b1, 12'hFFF, "rebound");

    // Miss #1: paddle moved to 0, ball falls 458 ticks after the hit
    frames(50, 1'b0, 1'b1, 1'b0);
    frames(406, 1'b0, 1'b0, 1'b0);
    ctrs(3, 1, 1'b0, "miss1_pre");
    frames(1, 1'b0, 1'b0, 1'b0);
    ctrs(2, 1, 1'b0, "miss1");
    probe(28, 442, 1'b1, 12'hFFF, "repark");

    // Miss #2 and #3 from serves at paddle 0
    frames(1, 1'b0, 1'b0, 1'b1);
    frames(457, 1'b0, 1'b0, 1'b0);
    ctrs(2, 1, 1'b0, "miss2_pre");
    frames(1, 1'b0, 1'b0, 1'b0);
    ctrs(1, 1, 1'b0, "miss2");
    frames(1, 1'b0, 1'b0, 1'b1);
    frames(458, 1'b0, 1'b0, 1'b0);
    ctrs(0, 1, 1'b1, "over");
    probe(0, 452, 1'b1, 12'hF00, "over_pad");
    probe(64, 452, 1'b1, 12'h000, "over_pad_end");
    probe(322, 472, 1'b1, 12'hFFF, "over_ball");
    frames(3, 1'b1, 1'b0, 1'b0);
    ctrs(0, 1, 1'b1, "over_hold");
    probe(0, 452, 1'b1, 12'hF00, "over_frozen");

    // Restart
    frames(1, 1'b0, 1'b0, 1'b1);
    ctrs(3, 0, 1'b0, "restart");
    probe(0, 452, 1'b1, 12'h0F0, "restart_pad");
    probe(28, 442, 1'b1, 12'hFFF, "restart_park");

    // Blanking and async reset mid-PLAY (ball at (48,422) after 10 ticks)
    frames(1, 1'b0, 1'b0, 1'b1);
    frames(10, 1'b0, 1'b0, 1'b0);
    probe(48, 422, 1'b1, 12'hFFF, "play_ball");
    probe(48, 422, 1'b0, 12'h000, "blank");
    probe(48, 422, 1'b1, 12'hFFF, "play_ball2");
    async_reset_check("arst");
    rstn = 1'b1;
    probe(316, 442, 1'b1, 12'hFFF, "arst_park");
    probe(288, 452, 1'b1, 12'h0F0, "arst_pad");
    probe(287, 452, 1'b1, 12'h000, "arst_pad_left");
    probe(48, 422, 1'b1, 12'h000, "arst_old_ball");

    repeat (3) @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL leftover: got %0d pending want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
